fir_pipe_param: RTL
===================

FIR_PIPE_PARAM -- requirements
Module: fir_pipe_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: signed input sample width.
REQ-002 The block SHALL have parameter COEF_W, default 8: signed coefficient width.
REQ-003 The block SHALL have parameter TAPS, default 5: number of filter taps, legal range 2..32.
REQ-004 The block SHALL have parameter CUT, default 2: number of leading taps summed before the pipeline cutset register, legal range 1..TAPS-1.
REQ-005 The block SHALL have derived constant OUT_W = DATA_W+COEF_W+clog2(TAPS): full-precision output width.
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port in_valid, input, 1: sample strobe.
REQ-009 Port in_data, input, DATA_W: signed two's-complement sample.
REQ-010 Port coef_we, input, 1: write strobe for the shadow coefficient bank.
REQ-011 Port coef_addr, input, clog2(TAPS): tap index to write.
REQ-012 Port coef_data, input, COEF_W: signed coefficient value.
REQ-013 Port coef_swap, input, 1: copies the shadow bank into the active bank.
REQ-014 Port out_valid, output, 1: result strobe.
REQ-015 Port out_data, output, OUT_W: signed filter result.

Function
REQ-016 The block SHALL accept a sample in every cycle in which in_valid=1; it has no backpressure.
REQ-017 The block SHALL advance the sample history only on accepted samples; idle cycles never shift it.
REQ-018 For accepted sample n, the block SHALL produce out_data = sum over k=0..TAPS-1 of h[k]*x[n-k].
- h is the active bank at the time sample n is accepted.
- x[n-k] is the k-th previously accepted sample; history before reset or never filled counts as 0.
REQ-019 Arithmetic SHALL be signed full precision; no truncation, rounding or overflow is permitted for any legal input.
REQ-020 The datapath SHALL be split by one register stage (cutset) after the partial sum of taps 0..CUT-1.
- Taps CUT..TAPS-1 are added in the second stage.
- Stage 1 carries its own registered copy of the samples for those taps, so results stay correct across idle gaps.
REQ-021 Latency SHALL be exactly 2 cycles: in_valid=1 at edge t gives out_valid=1 with the matching out_data at edge t+2.
REQ-022 out_valid SHALL be 1 for exactly one cycle per accepted sample; back-to-back inputs give back-to-back outputs, in order.
REQ-023 out_data SHALL hold its last value while out_valid=0.
REQ-024 coef_we=1 SHALL write coef_data to shadow[coef_addr]; an address >= TAPS is ignored.
REQ-025 coef_swap=1 SHALL copy the shadow bank into the active bank at that edge.
REQ-026 A sample accepted in the same cycle as coef_swap SHALL use the old active bank; samples accepted later use the new bank.
REQ-027 A sample already in the pipeline SHALL complete with the bank it was accepted with.
REQ-028 When coef_we and coef_swap are both 1 in the same cycle, the swap SHALL copy the shadow bank as it was before that write.

Reset
REQ-029 At a clock edge with rst=1, the block SHALL clear the sample history, the stage registers, both coefficient banks, out_valid and out_data to 0.
REQ-030 Reset SHALL override all other inputs in the same cycle and SHALL discard samples in flight: no out_valid for them afterwards.
REQ-031 The first sample accepted after reset SHALL see an all-zero history.

Verification
REQ-032 With defaults, h={1,2,3,4,5} loaded and swapped, feed an impulse then zeros: x=1,0,0,0,0,0 -> out_data 1,2,3,4,5,0, each 2 cycles after its input.
REQ-033 With h all -128, feed five consecutive x=-128 -> outputs 16384, 32768, 49152, 65536, 81920; checks signed full precision at OUT_W=19.
REQ-034 Repeat the REQ-032 impulse test with idle cycles of random length (0..3) between samples -> identical output sequence; out_valid pulses correspond 1:1 with inputs at latency 2.
REQ-035 Stream x=1 continuously and swap from h={1,1,1,1,1} to h={2,2,2,2,2} at sample 10 -> the sample accepted with the swap outputs 5; the following outputs are 10.
REQ-036 Assert rst for one cycle while 2 samples are in flight -> no out_valid for those samples; out_data=0; the next impulse after reset returns 0,0,0,0,0 because both banks are cleared.
REQ-037 Compare against a reference model for random parameters (TAPS 2..8, CUT 1..TAPS-1), random coefficients, random data and random in_valid -> zero mismatches.

Source files
------------

// File: rtl/fir_pipe_param.sv
// Parameterised direct-form FIR with double-buffered coefficients and a single
// pipeline cutset after the first CUT taps; fixed two-cycle latency.
module fir_pipe_param #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 5,
    parameter int CUT    = 2,
    localparam int OUT_W = DATA_W + COEF_W + $clog2(TAPS),
    localparam int AW    = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_we,
    input  logic        [AW-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     coef_swap,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data
);
    localparam int PW = DATA_W + COEF_W;
    localparam int NB = TAPS - CUT;

    logic signed [COEF_W-1:0] shadow [TAPS];
    logic signed [COEF_W-1:0] active [TAPS];
    logic signed [DATA_W-1:0] hist   [TAPS-1];
    logic signed [DATA_W-1:0] taps_x [TAPS];
    logic signed [DATA_W-1:0] s1_x   [NB];
    logic signed [COEF_W-1:0] s1_h   [NB];
    logic signed [PW-1:0]     prod1;
    logic signed [PW-1:0]     prod2;
    logic signed [OUT_W-1:0]  s1_sum;
    logic signed [OUT_W-1:0]  sum1;
    logic signed [OUT_W-1:0]  sum2;
    logic                     s1_valid;
    logic                     coef_hit;

    assign coef_hit = coef_we && ({1'b0, coef_addr} < (AW+1)'(TAPS));

    // taps_x[k] is x[n-k] for the sample currently on in_data
    always_comb begin
        taps_x[0] = in_data;
        for (int k = 1; k < TAPS; k++) begin
            taps_x[k] = hist[k-1];
        end
    end

    always_comb begin
        sum1  = '0;
        prod1 = '0;
        for (int k = 0; k < CUT; k++) begin
            prod1 = active[k] * taps_x[k];
            sum1  = sum1 + OUT_W'(prod1);
        end
    end

    // Second stage uses its own captured samples and coefficients, so a bank
    // swap or idle gap after acceptance cannot disturb an in-flight result.
    always_comb begin
        sum2  = s1_sum;
        prod2 = '0;
        for (int j = 0; j < NB; j++) begin
            prod2 = s1_h[j] * s1_x[j];
            sum2  = sum2 + OUT_W'(prod2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '{default: '0};
            active    <= '{default: '0};
            hist      <= '{default: '0};
            s1_x      <= '{default: '0};
            s1_h      <= '{default: '0};
            s1_sum    <= '0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (coef_hit) begin
                shadow[coef_addr] <= coef_data;
            end
            // Non-blocking copy: a same-cycle write is not seen by the swap
            if (coef_swap) begin
                active <= shadow;
            end
            if (in_valid) begin
                hist[0] <= in_data;
                for (int i = 1; i < TAPS - 1; i++) begin
                    hist[i] <= hist[i-1];
                end
                for (int j = 0; j < NB; j++) begin
                    s1_x[j] <= taps_x[CUT+j];
                    s1_h[j] <= active[CUT+j];
                end
                s1_sum <= sum1;
            end
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= sum2;
            end
        end
    end

endmodule
